// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the program-counter generator.
//   INSTR_BYTES : fetch granule in bytes (sequential PC step).
//   pc_state_e  : fetch FSM state encoding (FAULT only exists when
//                 PC_MISALIGN_CHECK_EN is defined).
package pc_gen_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01
`ifdef PC_MISALIGN_CHECK_EN
    ,
    FAULT = 2'b10
`endif
  } pc_state_e;

endpackage

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with a valid/ready fetch request.
//
// Configuration macro: PC_MISALIGN_CHECK_EN
//   defined   - a redirect to a non word-aligned target loads that target,
//               withdraws the fetch request and parks in FAULT with
//               misalign_o=1 until a trap or reset.
//   undefined - redirect targets are force-aligned (low two bits cleared)
//               and misalign_o is tied low.
//
// Ports:
//   clk               : clock, all state changes on the rising edge
//   reset             : synchronous active-high reset
//   stall_i           : pipeline stall, blocks sequential advance only
//   redirect_i        : branch/jump taken, load redirect_target_i
//   redirect_target_i : branch/jump target address
//   trap_i            : trap request, load TRAP_VECTOR (highest priority)
//   fetch_ready_i     : instruction memory accepts the current request
//   fetch_valid_o     : fetch request valid at pc_o (registered)
//   pc_o              : current fetch address (registered)
//   pc_plus4_o        : pc_o + 4, wrapping modulo 2^XLEN
//   misalign_o        : last redirect target was not word aligned
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] STEP_BYTES = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  pc_state_e       state_r;
  logic            advance_s;
  logic [XLEN-1:0] target_s;
`ifdef PC_MISALIGN_CHECK_EN
  logic            target_misaligned_s;
`endif

  // Sequential increment; the adder simply wraps at 2^XLEN.
  assign pc_plus4_o = pc_o + STEP_BYTES;

  // Handshake completion and the effective redirect address.
  always_comb begin
    advance_s = fetch_valid_o & fetch_ready_i & ~stall_i;
`ifdef PC_MISALIGN_CHECK_EN
    // Keep the raw target so the faulting address is visible on pc_o.
    target_s            = redirect_target_i;
    target_misaligned_s = |redirect_target_i[1:0];
`else
    target_s = redirect_target_i & ALIGN_MASK;
`endif
  end

`ifndef PC_MISALIGN_CHECK_EN
  assign misalign_o = 1'b0;
`endif

  // Fetch FSM with registered pc/valid/misalign outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= BOOT;
      pc_o          <= RESET_VECTOR;
      fetch_valid_o <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_o    <= 1'b0;
`endif
    end else begin
      case (state_r)
        BOOT: begin
          // Redirects and traps are ignored until the first request is up.
          state_r       <= RUN;
          pc_o          <= RESET_VECTOR;
          fetch_valid_o <= 1'b1;
        end
        RUN: begin
          if (trap_i) begin
            pc_o          <= TRAP_VECTOR;
            fetch_valid_o <= 1'b1;
          end else if (redirect_i) begin
            // A redirect cancels any unaccepted request, so ready/stall are moot.
            pc_o <= target_s;
`ifdef PC_MISALIGN_CHECK_EN
            if (target_misaligned_s) begin
              state_r       <= FAULT;
              fetch_valid_o <= 1'b0;
              misalign_o    <= 1'b1;
            end else begin
              fetch_valid_o <= 1'b1;
            end
`else
            fetch_valid_o <= 1'b1;
`endif
          end else if (advance_s) begin
            pc_o <= pc_plus4_o;
          end else begin
            // Request must stay stable until the memory accepts it.
            pc_o <= pc_o;
          end
        end
`ifdef PC_MISALIGN_CHECK_EN
        FAULT: begin
          if (trap_i) begin
            state_r       <= RUN;
            pc_o          <= TRAP_VECTOR;
            fetch_valid_o <= 1'b1;
            misalign_o    <= 1'b0;
          end else begin
            pc_o <= pc_o;
          end
        end
`endif
        default: begin
          // Unreachable encodings recover through the boot sequence.
          state_r       <= BOOT;
          pc_o          <= RESET_VECTOR;
          fetch_valid_o <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
          misalign_o    <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, meaning PC and address width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, meaning PC value loaded by reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, meaning PC value loaded by trap_i.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall_i  input  1  pipeline stall; freezes sequential advance.
REQ-007 redirect_i  input  1  branch/jump taken this cycle.
REQ-008 redirect_target_i  input  XLEN  branch/jump target address.
REQ-009 trap_i  input  1  exception/trap request.
REQ-010 fetch_ready_i  input  1  instruction memory accepts request.
REQ-011 fetch_valid_o  output  1  fetch request valid at pc_o.
REQ-012 pc_o  output  XLEN  current fetch address (registered).
REQ-013 pc_plus4_o  output  XLEN  pc_o + 4, modulo 2^XLEN (combinational from pc_o).
REQ-014 misalign_o  output  1  redirect target not 4-byte aligned (macro-dependent).

Function
REQ-015 The FSM SHALL have states BOOT, RUN and, when PC_MISALIGN_CHECK_EN is defined, FAULT.
REQ-016 BOOT SHALL drive fetch_valid_o=0, hold pc_o=RESET_VECTOR, and go to RUN next cycle unconditionally.
REQ-017 RUN SHALL drive fetch_valid_o=1.
REQ-018 Next-PC priority in RUN SHALL be: trap_i > redirect_i > advance > hold.
REQ-019 trap_i in RUN or FAULT SHALL load pc_o=TRAP_VECTOR next cycle and enter RUN, regardless of stall_i and fetch_ready_i.
REQ-020 redirect_i in RUN SHALL load pc_o=redirect_target_i next cycle regardless of stall_i and fetch_ready_i (cancels outstanding request).
REQ-021 Advance SHALL occur only when fetch_valid_o & fetch_ready_i & !stall_i, loading pc_o=pc_plus4_o.
REQ-022 With no advance, redirect or trap, pc_o and fetch_valid_o SHALL hold (request stays stable until accepted).
REQ-023 Increment SHALL wrap: pc_o=XLEN'hFFFF_FFFC advancing gives 0, no flag.
REQ-024 redirect_i and trap_i in BOOT SHALL be ignored.

Reset
REQ-025 reset sampled high SHALL, at that edge, set state=BOOT, pc_o=RESET_VECTOR, fetch_valid_o=0, misalign_o=0, overriding all other inputs.
REQ-026 reset asserted mid-request (fetch_valid_o=1, not accepted) SHALL drop the request without handshake completion.

Configuration
REQ-027 Macro PC_MISALIGN_CHECK_EN defined: redirect in RUN with redirect_target_i[1:0]!=0 SHALL load pc_o=target, enter FAULT; FAULT drives fetch_valid_o=0, misalign_o=1, holds pc_o, ignores redirect_i and stall_i, exits only via trap_i or reset.
REQ-028 Macro undefined: redirect SHALL load {redirect_target_i[XLEN-1:2],2'b00}; misalign_o SHALL be tied 0; no FAULT state exists.

Structure
REQ-029 Package pc_gen_pkg SHALL hold the state enum typedef and constant INSTR_BYTES=4.
REQ-030 Block SHALL be a single module; no sub-module.

Verification
REQ-031 Reset 1 cycle, release, fetch_ready_i=1 -> BOOT cycle valid=0 pc=0x0, then pc 0x0,0x4,0x8 valid=1 each cycle.
REQ-032 In RUN at pc=0x10, fetch_ready_i=0 for 3 cycles then 1 -> pc holds 0x10, valid=1 throughout, then 0x14; repeat with stall_i=1 -> same hold.
REQ-033 At pc=0x20, redirect_i=1 target=0x40 with trap_i=1 same cycle -> next pc=0x100; redirect alone with fetch_ready_i=0 -> next pc=0x40.
REQ-034 pc=0xFFFF_FFFC, advance -> pc=0x0000_0000, pc_plus4_o=0x4.
REQ-035 Redirect target 0x42: macro defined -> pc=0x42, valid=0, misalign_o=1 until trap_i, then pc=0x100 valid=1; macro undefined -> pc=0x40, misalign_o=0.
REQ-036 reset asserted at pc=0x30 with fetch_ready_i=0 -> next cycle pc=0x0, valid=0, misalign_o=0, state BOOT.
